scroll_decoder: RTL and testbench

SCROLL_DECODER -- requirements
Module: scroll_decoder

---
 rtl/scroll_decoder.sv | 164 ++++++++++++++++
 tb/tb_scroll_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_decoder.sv
// Tracks a three-LED bar bouncing across an 8-bit scroll display, locks onto its
// motion, counts end-of-travel reversals and flags samples that break the sequence.
module scroll_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [7:0]       pattern_in,
   output logic [2:0]       pos,
   output logic             dir,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] bounce_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [2:0] POS_MAX = 3'd5;

   state_t           state_reg;
   logic [2:0]       pos_reg;
   logic             dir_reg;
   logic             locked_reg;
   logic             error_reg;
   logic [CNT_W-1:0] bounce_reg;
   logic [CNT_W-1:0] err_reg;

   // One comparator per legal bar position; at most one can match.
   logic [5:0] match;
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_match
         assign match[gi] = (pattern_in == (8'b0000_0111 << gi));
      end
   endgenerate

   logic       sample_valid;
   logic [2:0] sample_pos;

   always_comb begin
      sample_valid = |match;
      sample_pos   = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (match[i]) begin
            sample_pos = 3'(i);
         end
      end
   end

   // Position the bar must reach next while locked, reflecting off either end.
   logic [2:0] exp_pos;
   logic       exp_dir;
   logic       exp_rev;

   always_comb begin
      exp_pos = pos_reg;
      exp_dir = dir_reg;
      exp_rev = 1'b0;
      if (!dir_reg) begin
         if (pos_reg == 3'd0) begin
            exp_pos = 3'd1;
            exp_dir = 1'b1;
            exp_rev = 1'b1;
         end else begin
            exp_pos = pos_reg - 3'd1;
         end
      end else begin
         if (pos_reg == POS_MAX) begin
            exp_pos = POS_MAX - 3'd1;
            exp_dir = 1'b0;
            exp_rev = 1'b1;
         end else begin
            exp_pos = pos_reg + 3'd1;
         end
      end
   end

   logic adjacent;
   logic hit_expected;
   logic stall;

   always_comb begin
      adjacent     = ({1'b0, sample_pos} == {1'b0, pos_reg} + 4'd1) ||
                     ({1'b0, pos_reg} == {1'b0, sample_pos} + 4'd1);
      hit_expected = sample_valid && (sample_pos == exp_pos);
      stall        = sample_valid && (sample_pos == pos_reg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= HUNT;
         pos_reg    <= 3'd0;
         dir_reg    <= 1'b0;
         locked_reg <= 1'b0;
         error_reg  <= 1'b0;
         bounce_reg <= '0;
         err_reg    <= '0;
      end else begin
         error_reg <= 1'b0;
         if (sample_en) begin
            case (state_reg)
               HUNT: begin
                  if (sample_valid) begin
                     state_reg <= SYNC;
                     pos_reg   <= sample_pos;
                  end
               end
               SYNC: begin
                  if (!sample_valid) begin
                     state_reg <= HUNT;
                  end else if (adjacent) begin
                     state_reg  <= LOCKED;
                     locked_reg <= 1'b1;
                     dir_reg    <= (sample_pos > pos_reg);
                     pos_reg    <= sample_pos;
                  end else begin
                     pos_reg <= sample_pos;
                  end
               end
               LOCKED: begin
                  if (hit_expected) begin
                     pos_reg <= exp_pos;
                     dir_reg <= exp_dir;
                     if (exp_rev && (bounce_reg != {CNT_W{1'b1}})) begin
                        bounce_reg <= bounce_reg + 1'b1;
                     end
                  end else if (!stall) begin
                     // Sequence broken: resync on a valid bar, otherwise hunt from scratch.
                     error_reg  <= 1'b1;
                     locked_reg <= 1'b0;
                     if (err_reg != {CNT_W{1'b1}}) begin
                        err_reg <= err_reg + 1'b1;
                     end
                     if (sample_valid) begin
                        state_reg <= SYNC;
                        pos_reg   <= sample_pos;
                     end else begin
                        state_reg <= HUNT;
                     end
                  end
               end
               default: begin
                  state_reg  <= HUNT;
                  locked_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pos        = pos_reg;
   assign dir        = dir_reg;
   assign locked     = locked_reg;
   assign error      = error_reg;
   assign bounce_cnt = bounce_reg;
   assign err_cnt    = err_reg;

endmodule

// File: tb/tb_scroll_decoder.sv
// Self-checking bench for scroll_decoder: a positional model of the bouncing bar
// checked every cycle, plus literal expectations at key points.
module tb_scroll_decoder;

   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             sample_en = 1'b0;
   logic [7:0]       pattern_in = 8'h00;
   logic [2:0]       pos;
   logic             dir;
   logic             locked;
   logic             error;
   logic [CNT_W-1:0] bounce_cnt;
   logic [CNT_W-1:0] err_cnt;

   scroll_decoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_en  (sample_en),
      .pattern_in (pattern_in),
      .pos        (pos),
      .dir        (dir),
      .locked     (locked),
      .error      (error),
      .bounce_cnt (bounce_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   // Model: mode 0 = hunting, 1 = one bar seen, 2 = following the motion.
   int m_mode = 0;
   int m_pos = 0;
   int m_dir = 0;
   int m_bounce = 0;
   int m_err = 0;
   int m_error = 0;

   function automatic logic [7:0] bar(input int p);
      logic [7:0] b;
      b = 8'd7;
      return b << p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit en, input logic [7:0] p);
      bit v;
      int low;
      int step;
      int nxt;
      int ndir;
      bit rev;
      m_error = 0;
      if (r) begin
         m_mode = 0; m_pos = 0; m_dir = 0; m_bounce = 0; m_err = 0;
         return;
      end
      if (!en) return;
      low = 0;
      for (int k = 7; k >= 0; k--) if (p[k]) low = k;
      v = (p != 0) && ($countones(p) == 3) && ((p >> low) == 8'd7);
      case (m_mode)
         0: if (v) begin m_mode = 1; m_pos = low; end
         1: begin
            if (!v) m_mode = 0;
            else if (low - m_pos == 1 || m_pos - low == 1) begin
               m_mode = 2; m_dir = (low > m_pos) ? 1 : 0; m_pos = low;
            end else m_pos = low;
         end
         default: begin
            step = m_dir ? 1 : -1;
            nxt = m_pos + step;
            ndir = m_dir;
            rev = 0;
            if (nxt < 0 || nxt > 5) begin
               nxt = m_pos - step; ndir = 1 - m_dir; rev = 1;
            end
            if (v && low == nxt) begin
               m_pos = nxt; m_dir = ndir;
               if (rev && m_bounce < CMAX) m_bounce++;
            end else if (!(v && low == m_pos)) begin
               m_error = 1;
               if (m_err < CMAX) m_err++;
               if (v) begin m_mode = 1; m_pos = low; end
               else m_mode = 0;
            end
         end
      endcase
   endtask

   task automatic cycle(input bit r, input bit en, input logic [7:0] p);
      reset = r; sample_en = en; pattern_in = p;
      @(posedge clk);
      #1;
      model_step(r, en, p);
      if (r) chk_on = 1'b1;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("pos", 32'(pos), 32'(m_pos));
         check("dir", 32'(dir), 32'(m_dir));
         check("locked", 32'(locked), 32'(m_mode == 2));
         check("error", 32'(error), 32'(m_error));
         check("bounce_cnt", 32'(bounce_cnt), 32'(m_bounce));
         check("err_cnt", 32'(err_cnt), 32'(m_err));
      end
   end

   int seq030[12] = '{5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4};
   logic [7:0] junk[6] = '{8'h00, 8'h0F, 8'h15, 8'hC1, 8'hFF, 8'h06};

   initial begin
      // Reset state
      cycle(1, 0, 8'h00);
      check("rst_pos", 32'(pos), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      $display("reset done");

      // Acquire lock on a bar moving toward bit 0
      cycle(0, 1, 8'b1110_0000);
      check("acq1_pos", 32'(pos), 5);
      check("acq1_locked", 32'(locked), 0);
      cycle(0, 1, 8'b0111_0000);
      check("acq2_pos", 32'(pos), 4);
      check("acq2_locked", 32'(locked), 1);
      check("acq2_dir", 32'(dir), 0);
      cycle(0, 1, 8'b0011_1000);
      check("acq3_pos", 32'(pos), 3);
      check("acq3_error", 32'(error), 0);
      $display("acquire: pos=%0d dir=%0d locked=%0d", pos, dir, locked);

      // Blank sample while locked at pos 3
      cycle(0, 1, 8'h00);
      check("blank_error", 32'(error), 1);
      check("blank_err_cnt", 32'(err_cnt), 1);
      check("blank_locked", 32'(locked), 0);
      check("blank_pos", 32'(pos), 3);
      cycle(0, 0, 8'h00);
      check("blank_error_gone", 32'(error), 0);
      $display("blank sample: err_cnt=%0d", err_cnt);

      // Full bounce sequence after reset
      cycle(1, 0, 8'h00);
      foreach (seq030[i]) begin
         cycle(0, 1, bar(seq030[i]));
         $display("bounce step %0d: pos=%0d dir=%0d bounce_cnt=%0d", i, pos, dir, bounce_cnt);
      end
      check("bounce_cnt", 32'(bounce_cnt), 2);
      check("bounce_dir", 32'(dir), 0);
      check("bounce_pos", 32'(pos), 4);
      check("bounce_err_cnt", 32'(err_cnt), 0);

      // Skip from pos 4 to 2, then resume
      cycle(0, 1, 8'b0001_1100);
      check("skip_error", 32'(error), 1);
      cycle(0, 1, 8'b0000_1110);
      check("skip_locked", 32'(locked), 1);
      check("skip_pos", 32'(pos), 1);
      check("skip_dir", 32'(dir), 0);
      $display("skip: locked=%0d pos=%0d err_cnt=%0d", locked, pos, err_cnt);

      // Disabled samples are ignored; a repeated bar is a stall
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, (i % 2) ? 8'hFF : bar(i % 6));
         $display("idle %0d: pos=%0d locked=%0d error=%0d", i, pos, locked, error);
      end
      check("idle_pos", 32'(pos), 1);
      check("idle_locked", 32'(locked), 1);
      cycle(0, 1, 8'b0000_1110);
      check("stall_pos", 32'(pos), 1);
      check("stall_error", 32'(error), 0);
      check("stall_err_cnt", 32'(err_cnt), 1);
      check("stall_bounce", 32'(bounce_cnt), 2);

      // Invalid patterns in HUNT, non-adjacent resync in SYNC
      cycle(1, 0, 8'h00);
      foreach (junk[i]) begin
         cycle(0, 1, junk[i]);
         $display("junk %02h: locked=%0d error=%0d", junk[i], locked, error);
      end
      check("junk_pos", 32'(pos), 0);
      cycle(0, 1, bar(0));
      cycle(0, 1, bar(3));
      check("sync_far_pos", 32'(pos), 3);
      check("sync_far_locked", 32'(locked), 0);
      cycle(0, 1, 8'h0F);
      cycle(0, 1, bar(2));
      cycle(0, 1, bar(3));
      check("relock_dir", 32'(dir), 1);
      check("relock_locked", 32'(locked), 1);

      // Saturate err_cnt with 300 violations, then reset mid-lock with a sample
      cycle(1, 0, 8'h00);
      cycle(0, 1, bar(0));
      cycle(0, 1, bar(1));
      for (int i = 0; i < 150; i++) begin
         cycle(0, 1, bar(3));
         cycle(0, 1, bar(4));
         cycle(0, 1, bar(0));
         cycle(0, 1, bar(1));
      end
      $display("saturate: err_cnt=%0d locked=%0d", err_cnt, locked);
      check("sat_err_cnt", 32'(err_cnt), 255);
      check("sat_locked", 32'(locked), 1);
      cycle(1, 1, bar(2));
      check("post_rst_pos", 32'(pos), 0);
      check("post_rst_dir", 32'(dir), 0);
      check("post_rst_locked", 32'(locked), 0);
      check("post_rst_error", 32'(error), 0);
      check("post_rst_bounce", 32'(bounce_cnt), 0);
      check("post_rst_err_cnt", 32'(err_cnt), 0);
      $display("reset with sample: pos=%0d err_cnt=%0d", pos, err_cnt);
      cycle(0, 0, 8'h00);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
